multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath (PC, InsReg, RF, ALU, DataMem, NPC).

---
 rtl/multicycle_ctrl_pkg.sv | 86 ++++++++
 rtl/multicycle_ctrl_decode.sv | 52 +++++
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg
//   Shared encodings for the multi-cycle MIPS sequencer: FSM states,
//   instruction classes, ALU function codes, NPC/RegDst/RegSrc selects
//   and the opcode/funct values the decoder recognises.
//   No ports; imported by multicycle_ctrl and multicycle_ctrl_decode.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ERR    = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      CLS_NONE = 4'd0,
      CLS_RALU = 4'd1,
      CLS_IALU = 4'd2,
      CLS_LW   = 4'd3,
      CLS_SW   = 4'd4,
      CLS_BEQ  = 4'd5,
      CLS_BNE  = 4'd6,
      CLS_J    = 4'd7,
      CLS_JAL  = 4'd8,
      CLS_JR   = 4'd9
   } iclass_e;

   localparam logic [3:0] ALU_NOP = 4'd0;
   localparam logic [3:0] ALU_ADD = 4'd1;
   localparam logic [3:0] ALU_SUB = 4'd2;
   localparam logic [3:0] ALU_AND = 4'd3;
   localparam logic [3:0] ALU_OR  = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;
   localparam logic [3:0] ALU_SLL = 4'd6;
   localparam logic [3:0] ALU_SRL = 4'd7;
   localparam logic [3:0] ALU_LUI = 4'd8;

   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_RS     = 2'b11;

   localparam logic [1:0] RD_RT  = 2'b00;
   localparam logic [1:0] RD_RD  = 2'b01;
   localparam logic [1:0] RD_R31 = 2'b10;

   localparam logic [1:0] RS_ALU = 2'b00;
   localparam logic [1:0] RS_MEM = 2'b01;
   localparam logic [1:0] RS_PC4 = 2'b10;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_SLT  = 6'h2A;

   // Shifts take the shift amount on ALU port A instead of RD1.
   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL);
   endfunction

   // Immediate-operand classes feed imm32 to ALU port B.
   function automatic logic uses_imm(input iclass_e c);
      return (c == CLS_IALU) || (c == CLS_LW) || (c == CLS_SW);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode
//   Purely combinational instruction decoder: maps opcode/funct to an
//   instruction class, the ALU function code and an illegal flag.
//   Ports:
//     opcode  in  6  inst[31:26]
//     funct   in  6  inst[5:0]
//     iclass  out    instruction class (CLS_NONE when illegal)
//     alu_op  out 4  ALU function code for the execute step
//     illegal out 1  opcode/funct not recognised
module multicycle_ctrl_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_e    iclass,
   output logic [3:0] alu_op,
   output logic       illegal
);

   // Opcode/funct decode table.
   always_comb begin
      iclass  = CLS_NONE;
      alu_op  = ALU_NOP;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_ADD, F_ADDU: begin iclass = CLS_RALU; alu_op = ALU_ADD; end
               F_SUB, F_SUBU: begin iclass = CLS_RALU; alu_op = ALU_SUB; end
               F_AND:         begin iclass = CLS_RALU; alu_op = ALU_AND; end
               F_OR:          begin iclass = CLS_RALU; alu_op = ALU_OR;  end
               F_SLT:         begin iclass = CLS_RALU; alu_op = ALU_SLT; end
               F_SLL:         begin iclass = CLS_RALU; alu_op = ALU_SLL; end
               F_SRL:         begin iclass = CLS_RALU; alu_op = ALU_SRL; end
               F_JR:          iclass = CLS_JR;
               default:       illegal = 1'b1;
            endcase
         end
         OP_J:              iclass = CLS_J;
         OP_JAL:            iclass = CLS_JAL;
         OP_BEQ:            begin iclass = CLS_BEQ;  alu_op = ALU_SUB; end
         OP_BNE:            begin iclass = CLS_BNE;  alu_op = ALU_SUB; end
         OP_ADDI, OP_ADDIU: begin iclass = CLS_IALU; alu_op = ALU_ADD; end
         OP_ORI:            begin iclass = CLS_IALU; alu_op = ALU_OR;  end
         OP_LUI:            begin iclass = CLS_IALU; alu_op = ALU_LUI; end
         OP_LW:             begin iclass = CLS_LW;   alu_op = ALU_ADD; end
         OP_SW:             begin iclass = CLS_SW;   alu_op = ALU_ADD; end
         default:           illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle sequencer for the MIPS datapath. Steps each instruction
//   through FETCH/DECODE/EXEC/MEM/WB so one memory and one ALU are shared
//   across cycles; all datapath selects/enables are decoded from the
//   current state and the instruction register's opcode/funct.
//   Optional build macro: MULTICYCLE_MEM_WAIT_EN -- FETCH and MEM stall
//   until mem_ready=1; without it mem_ready is ignored.
//   Ports:
//     clk, rst (async active-low)
//     opcode, funct            instruction fields from the IR
//     Zero                     ALU zero flag (branch resolution)
//     mem_ready                memory handshake (wait-state build only)
//     PCWr, IRWr, RegWrite, MemWrite   write enables
//     ALUSrcA, ALUSrcB, RegDst, RegSrc, ALUOp, NPCOp   datapath selects
//     retire                   pulse on the cycle PCWr fires
//     illegal                  sticky undecodable-instruction flag
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWr,
   output logic       IRWr,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [1:0] RegDst,
   output logic [1:0] RegSrc,
   output logic [3:0] ALUOp,
   output logic [1:0] NPCOp,
   output logic       retire,
   output logic       illegal
);

   state_e     state_q, state_d;
   logic       illegal_q, illegal_d;

   iclass_e    dec_class_s;
   logic [3:0] dec_alu_op_s;
   logic       dec_illegal_s;
   logic       mem_done_s;

   logic       pc_wr_s, ir_wr_s, reg_wr_s, mem_wr_s, src_a_s, src_b_s, retire_s;
   logic [1:0] reg_dst_s, reg_src_s, npc_op_s;
   logic [3:0] alu_op_s;

   multicycle_ctrl_decode u_decode (
      .opcode  (opcode),
      .funct   (funct),
      .iclass  (dec_class_s),
      .alu_op  (dec_alu_op_s),
      .illegal (dec_illegal_s)
   );

`ifdef MULTICYCLE_MEM_WAIT_EN
   assign mem_done_s = mem_ready;
`else
   // Every access completes in one cycle; the handshake is not observed.
   logic mem_ready_unused;
   assign mem_ready_unused = mem_ready;
   assign mem_done_s       = 1'b1;
`endif

   // State and sticky illegal flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state and per-state datapath control.
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      pc_wr_s   = 1'b0;
      ir_wr_s   = 1'b0;
      reg_wr_s  = 1'b0;
      mem_wr_s  = 1'b0;
      src_a_s   = 1'b0;
      src_b_s   = 1'b0;
      retire_s  = 1'b0;
      reg_dst_s = RD_RT;
      reg_src_s = RS_ALU;
      npc_op_s  = NPC_PLUS4;
      alu_op_s  = ALU_NOP;
      case (state_q)
         S_FETCH: begin
            ir_wr_s = mem_done_s;
            if (mem_done_s) state_d = S_DECODE;
            else            state_d = S_FETCH;
         end
         S_DECODE: begin
            if (dec_illegal_s) begin
               state_d   = S_ERR;
               illegal_d = 1'b1;
            end else begin
               case (dec_class_s)
                  CLS_J: begin
                     pc_wr_s = 1'b1; npc_op_s = NPC_JUMP; retire_s = 1'b1;
                     state_d = S_FETCH;
                  end
                  CLS_JAL: begin
                     pc_wr_s   = 1'b1; npc_op_s  = NPC_JUMP; retire_s = 1'b1;
                     reg_wr_s  = 1'b1; reg_dst_s = RD_R31;   reg_src_s = RS_PC4;
                     state_d   = S_FETCH;
                  end
                  CLS_JR: begin
                     pc_wr_s = 1'b1; npc_op_s = NPC_RS; retire_s = 1'b1;
                     state_d = S_FETCH;
                  end
                  default: state_d = S_EXEC;
               endcase
            end
         end
         S_EXEC: begin
            alu_op_s = dec_alu_op_s;
            src_a_s  = is_shift(dec_alu_op_s);
            src_b_s  = uses_imm(dec_class_s);
            case (dec_class_s)
               CLS_BEQ, CLS_BNE: begin
                  pc_wr_s  = 1'b1;
                  retire_s = 1'b1;
                  // beq takes on Zero, bne on ~Zero.
                  if ((dec_class_s == CLS_BEQ) ? Zero : ~Zero) npc_op_s = NPC_BRANCH;
                  else                                         npc_op_s = NPC_PLUS4;
                  state_d = S_FETCH;
               end
               CLS_LW, CLS_SW:     state_d = S_MEM;
               CLS_RALU, CLS_IALU: state_d = S_WB;
               default: begin
                  state_d   = S_ERR;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            // Keep the address on the ALU output for the whole access.
            alu_op_s = ALU_ADD;
            src_b_s  = 1'b1;
            case (dec_class_s)
               CLS_SW: begin
                  mem_wr_s = 1'b1;
                  if (mem_done_s) begin
                     pc_wr_s  = 1'b1;
                     retire_s = 1'b1;
                     state_d  = S_FETCH;
                  end else begin
                     state_d  = S_MEM;
                  end
               end
               CLS_LW: begin
                  if (mem_done_s) state_d = S_WB;
                  else            state_d = S_MEM;
               end
               default: begin
                  state_d   = S_ERR;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_WB: begin
            // ALU selects held so the ALU result is still valid at write-back.
            alu_op_s  = dec_alu_op_s;
            src_a_s   = is_shift(dec_alu_op_s);
            src_b_s   = uses_imm(dec_class_s);
            reg_wr_s  = 1'b1;
            pc_wr_s   = 1'b1;
            retire_s  = 1'b1;
            reg_dst_s = (dec_class_s == CLS_RALU) ? RD_RD  : RD_RT;
            reg_src_s = (dec_class_s == CLS_LW)   ? RS_MEM : RS_ALU;
            state_d   = S_FETCH;
         end
         S_ERR: begin
            state_d   = S_ERR;
            illegal_d = 1'b1;
         end
         default: begin
            state_d   = S_ERR;
            illegal_d = 1'b1;
         end
      endcase
   end

   // Gating with rst drops every output the instant reset asserts, so no
   // partial register-file or memory write can commit.
   assign PCWr     = rst & pc_wr_s;
   assign IRWr     = rst & ir_wr_s;
   assign RegWrite = rst & reg_wr_s;
   assign MemWrite = rst & mem_wr_s;
   assign retire   = rst & retire_s;
   assign ALUSrcA  = rst & src_a_s;
   assign ALUSrcB  = rst & src_b_s;
   assign RegDst   = rst ? reg_dst_s : 2'b00;
   assign RegSrc   = rst ? reg_src_s : 2'b00;
   assign ALUOp    = rst ? alu_op_s  : 4'd0;
   assign NPCOp    = rst ? npc_op_s  : 2'b00;
   assign illegal  = rst & illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected outputs are
// queued when an instruction is presented and compared as the DUT steps.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic       Zero, mem_ready;
   logic       PCWr, IRWr, RegWrite, MemWrite, ALUSrcA, ALUSrcB, retire, illegal;
   logic [1:0] RegDst, RegSrc, NPCOp;
   logic [3:0] ALUOp;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Zero(Zero),
      .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .RegDst(RegDst), .RegSrc(RegSrc), .ALUOp(ALUOp), .NPCOp(NPCOp),
      .retire(retire), .illegal(illegal)
   );

   // Observation vector:
   // [17]PCWr [16]IRWr [15]RegWrite [14]MemWrite [13]ALUSrcA [12]ALUSrcB
   // [11:10]RegDst [9:8]RegSrc [7:4]ALUOp [3:2]NPCOp [1]retire [0]illegal
   localparam logic [17:0] M_EN = 18'h3C003;

   typedef struct {
      logic [17:0] val;
      logic [17:0] msk;
      logic        rdy;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic logic [17:0] obs();
      return {PCWr, IRWr, RegWrite, MemWrite, ALUSrcA, ALUSrcB,
              RegDst, RegSrc, ALUOp, NPCOp, retire, illegal};
   endfunction

   task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   function automatic exp_t rec(input string tag);
      exp_t r;
      r.val = '0;
      r.msk = M_EN;
      r.rdy = 1'b1;
      r.tag = tag;
      return r;
   endfunction

   task automatic drain();
      exp_t r;
      while (sb_q.size() > 0) begin
         r = sb_q.pop_front();
         mem_ready = r.rdy;
         @(negedge clk);
         check_eq(r.tag, obs() & r.msk, r.val & r.msk);
         @(posedge clk); #1;
      end
   endtask

   // Reference model of one legal instruction; mw = cycles mem_ready is held low in MEM.
   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input int mw, input string nm);
      exp_t       r;
      int         cls;   // 0 R-alu 1 I-alu 2 lw 3 sw 4 beq 5 bne 6 j 7 jal 8 jr
      logic [3:0] aop;
      logic       sa, sb, last_rdy;
      int         waits;
      cls = 0; aop = 4'd0; sa = 1'b0; sb = 1'b0;
      case (op)
         6'h00: case (fn)
                   6'h21: aop = 4'd1;
                   6'h23: aop = 4'd2;
                   6'h24: aop = 4'd3;
                   6'h25: aop = 4'd4;
                   6'h2A: aop = 4'd5;
                   6'h00: begin aop = 4'd6; sa = 1'b1; end
                   6'h02: begin aop = 4'd7; sa = 1'b1; end
                   default: cls = 8;
                endcase
         6'h02: cls = 6;
         6'h03: cls = 7;
         6'h04: begin cls = 4; aop = 4'd2; end
         6'h05: begin cls = 5; aop = 4'd2; end
         6'h08: begin cls = 1; aop = 4'd1; sb = 1'b1; end
         6'h0D: begin cls = 1; aop = 4'd4; sb = 1'b1; end
         6'h0F: begin cls = 1; aop = 4'd8; sb = 1'b1; end
         6'h23: begin cls = 2; aop = 4'd1; sb = 1'b1; end
         default: begin cls = 3; aop = 4'd1; sb = 1'b1; end
      endcase
`ifdef MULTICYCLE_MEM_WAIT_EN
      waits = mw; last_rdy = 1'b1;
`else
      waits = 0;  last_rdy = (mw == 0);
`endif
      opcode = op; funct = fn; Zero = z;
      r = rec({nm, " fetch"}); r.val[16] = 1'b1; sb_q.push_back(r);
      r = rec({nm, " decode"});
      if (cls >= 6) begin
         r.val[17] = 1'b1; r.val[1] = 1'b1; r.msk[3:2] = 2'b11;
         r.val[3:2] = (cls == 8) ? 2'b11 : 2'b10;
         if (cls == 7) begin
            r.val[15] = 1'b1; r.msk[11:8] = 4'hF; r.val[11:10] = 2'b10; r.val[9:8] = 2'b10;
         end
         sb_q.push_back(r);
      end else begin
         sb_q.push_back(r);
         r = rec({nm, " exec"});
         r.msk[13:12] = 2'b11; r.msk[7:4] = 4'hF;
         r.val[13] = sa; r.val[12] = sb; r.val[7:4] = aop;
         if (cls == 4 || cls == 5) begin
            r.val[17] = 1'b1; r.val[1] = 1'b1; r.msk[3:2] = 2'b11;
            r.val[3:2] = ((cls == 4) == z) ? 2'b01 : 2'b00;
            sb_q.push_back(r);
         end else begin
            sb_q.push_back(r);
            if (cls == 2 || cls == 3) begin
               for (int i = 0; i < waits; i++) begin
                  r = rec({nm, " memwait"}); r.rdy = 1'b0;
                  r.msk[12] = 1'b1; r.msk[7:4] = 4'hF; r.val[12] = 1'b1; r.val[7:4] = 4'd1;
                  r.val[14] = (cls == 3);
                  sb_q.push_back(r);
               end
               r = rec({nm, " mem"}); r.rdy = last_rdy;
               r.msk[12] = 1'b1; r.msk[7:4] = 4'hF; r.val[12] = 1'b1; r.val[7:4] = 4'd1;
               r.val[14] = (cls == 3);
               if (cls == 3) begin
                  r.val[17] = 1'b1; r.val[1] = 1'b1; r.msk[3:2] = 2'b11;
               end
               sb_q.push_back(r);
            end
            if (cls != 3) begin
               r = rec({nm, " wb"});
               r.val[17] = 1'b1; r.val[15] = 1'b1; r.val[1] = 1'b1;
               r.msk[11:8] = 4'hF; r.msk[3:2] = 2'b11;
               r.val[11:10] = (cls == 0) ? 2'b01 : 2'b00;
               r.val[9:8]   = (cls == 2) ? 2'b01 : 2'b00;
               sb_q.push_back(r);
            end
         end
      end
      drain();
   endtask

   // Undecodable instruction: ERR with illegal=1 and no enables, cleared only by reset.
   task automatic issue_bad(input logic [5:0] op, input logic [5:0] fn, input string nm);
      exp_t r;
      opcode = op; funct = fn; Zero = 1'b0;
      r = rec({nm, " fetch"}); r.val[16] = 1'b1; sb_q.push_back(r);
      r = rec({nm, " decode"}); r.msk[0] = 1'b0; sb_q.push_back(r);
      for (int i = 0; i < 4; i++) begin
         r = rec({nm, " err"}); r.val[0] = 1'b1; sb_q.push_back(r);
      end
      drain();
      rst = 1'b0;
      @(negedge clk);
      check_eq({nm, " reset clears"}, obs(), 18'd0);
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   // Reset pulled in the MEM cycle of a store.
   task automatic sw_reset();
      exp_t r;
      opcode = 6'h2B; funct = 6'h00; Zero = 1'b0;
      r = rec("swr fetch");  r.val[16] = 1'b1; sb_q.push_back(r);
      r = rec("swr decode"); sb_q.push_back(r);
      r = rec("swr exec");   sb_q.push_back(r);
      drain();
      mem_ready = 1'b0;
      @(negedge clk);
      check_eq("swr mem MemWrite", {17'd0, MemWrite}, 18'd1);
      rst = 1'b0;
      #1;
      check_eq("swr rst drop", obs(), 18'd0);
      @(posedge clk); #1;
      check_eq("swr rst hold", obs(), 18'd0);
      rst = 1'b1;
      mem_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b1; opcode = 6'h3F; funct = 6'h3F; Zero = 1'b1;
      #1 rst = 1'b0;
      @(negedge clk); check_eq("reset outputs", obs(), 18'd0);
      @(negedge clk); check_eq("reset outputs 2", obs(), 18'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      issue(6'h00, 6'h21, 1'b0, 0, "addu");
      issue(6'h23, 6'h00, 1'b0, 3, "lw_wait");
      issue(6'h23, 6'h00, 1'b1, 0, "lw");
      issue(6'h2B, 6'h00, 1'b0, 0, "sw");
      issue(6'h2B, 6'h00, 1'b0, 2, "sw_wait");
      issue(6'h04, 6'h00, 1'b1, 0, "beq_taken");
      issue(6'h04, 6'h00, 1'b0, 0, "beq_not");
      issue(6'h05, 6'h00, 1'b0, 0, "bne_taken");
      issue(6'h05, 6'h00, 1'b1, 0, "bne_not");
      issue(6'h03, 6'h00, 1'b0, 0, "jal");
      issue(6'h02, 6'h00, 1'b0, 0, "j");
      issue(6'h00, 6'h08, 1'b0, 0, "jr");
      issue(6'h0D, 6'h00, 1'b0, 0, "ori");
      issue(6'h0F, 6'h00, 1'b0, 0, "lui");
      issue(6'h08, 6'h00, 1'b0, 0, "addi");
      issue(6'h00, 6'h00, 1'b0, 0, "sll");
      issue(6'h00, 6'h02, 1'b0, 0, "srl");
      issue(6'h00, 6'h2A, 1'b0, 0, "slt");
      issue(6'h00, 6'h23, 1'b0, 0, "subu");
      issue(6'h00, 6'h24, 1'b0, 0, "and");
      issue(6'h00, 6'h25, 1'b0, 0, "or");
      sw_reset();
      issue(6'h00, 6'h21, 1'b0, 0, "addu_after_rst");
      issue_bad(6'h3F, 6'h00, "bad_op");
      issue(6'h04, 6'h00, 1'b1, 0, "beq_after_err");
      issue_bad(6'h00, 6'h3F, "bad_funct");
      issue(6'h23, 6'h00, 1'b0, 0, "lw_after_err");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
